// File: rtl/esi_cosim_mmio_bridge.sv
// Cosim MMIO bridge: host requests polled from the cosim server are issued
// on a single-outstanding command/response bus and answered back to the host.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   cmd_valid/cmd_ready      command handshake (out/in)
//   cmd_write                1 = write, 0 = read
//   cmd_address, cmd_data    command byte address and write data (0 for reads)
//   resp_valid/resp_ready    response handshake (in/out)
//   resp_data, resp_error    read data and error flag from downstream
//   timeout_count            saturating count of timed-out transactions
//   spurious_count           saturating count of responses seen outside WAIT
//   enabled                  host registration succeeded

package esi_cosim_mmio_pkg;
    // Standalone host model: request queues in, response logs out.
    int          reg_status = 0;
    int unsigned rd_polls   = 0;
    int unsigned wr_polls   = 0;
    int unsigned rd_req_q[$];
    int unsigned wr_addr_q[$];
    int unsigned wr_data_q[$];
    int unsigned rd_resp_data_q[$];
    byte unsigned rd_resp_err_q[$];
    byte unsigned wr_resp_err_q[$];

    function automatic int cosim_mmio_register();
        return reg_status;
    endfunction

    function automatic int cosim_mmio_read_tryget(output int unsigned address);
        rd_polls++;
        address = 0;
        if (rd_req_q.size() == 0) return -1;
        address = rd_req_q.pop_front();
        return 0;
    endfunction

    function automatic int cosim_mmio_write_tryget(output int unsigned address,
                                                   output int unsigned data);
        wr_polls++;
        address = 0;
        data    = 0;
        if (wr_addr_q.size() == 0) return -1;
        address = wr_addr_q.pop_front();
        data    = wr_data_q.pop_front();
        return 0;
    endfunction

    function automatic void cosim_mmio_read_respond(input int unsigned data,
                                                    input byte unsigned error);
        rd_resp_data_q.push_back(data);
        rd_resp_err_q.push_back(error);
    endfunction

    function automatic void cosim_mmio_write_respond(input byte unsigned error);
        wr_resp_err_q.push_back(error);
    endfunction
endpackage

module esi_cosim_mmio_bridge
    import esi_cosim_mmio_pkg::*;
#(
    parameter int unsigned POLL_INTERVAL  = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_write,
    output logic [31:0] cmd_address,
    output logic [31:0] cmd_data,
    input  logic        resp_valid,
    output logic        resp_ready,
    input  logic [31:0] resp_data,
    input  logic        resp_error,
    output logic [15:0] timeout_count,
    output logic [15:0] spurious_count,
    output logic        enabled
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

    typedef struct packed {
        state_t      st;
        logic        write;
        logic [31:0] addr;
        logic [31:0] data;
    } ctl_t;

    localparam logic [15:0] POLL_RELOAD = 16'(POLL_INTERVAL - 1);
    localparam logic [31:0] TO_LAST =
        (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

    ctl_t        ctl, ctl_next;
    logic [15:0] poll_cnt;
    logic        poll_odd;
    logic [31:0] wait_cnt;
    logic        en_q;
    logic        poll_now;
    logic        resp_fire;
    logic        timeout_fire;

    // Registration happens once per simulation and is independent of rst.
    initial begin
        if (cosim_mmio_register() != 0) begin
            $error("esi_cosim_mmio_bridge: cosim_mmio_register failed");
            en_q = 1'b0;
        end else begin
            en_q = 1'b1;
        end
    end

    // One poll event. The second tryget only runs if the first misses.
    function automatic ctl_t poll_host(input ctl_t cur, input logic rd_first);
        ctl_t        r;
        int unsigned a;
        int unsigned d;
        r = cur;
        if (rd_first) begin
            if (cosim_mmio_read_tryget(a) == 0) begin
                r.st = ISSUE; r.write = 1'b0; r.addr = a; r.data = '0;
            end else if (cosim_mmio_write_tryget(a, d) == 0) begin
                r.st = ISSUE; r.write = 1'b1; r.addr = a; r.data = d;
            end
        end else begin
            if (cosim_mmio_write_tryget(a, d) == 0) begin
                r.st = ISSUE; r.write = 1'b1; r.addr = a; r.data = d;
            end else if (cosim_mmio_read_tryget(a) == 0) begin
                r.st = ISSUE; r.write = 1'b0; r.addr = a; r.data = '0;
            end
        end
        return r;
    endfunction

    function automatic void respond(input logic w, input logic [31:0] d,
                                    input logic e);
        if (w) cosim_mmio_write_respond({7'b0, e});
        else   cosim_mmio_read_respond(d, {7'b0, e});
    endfunction

    assign enabled     = en_q;
    assign cmd_valid   = (ctl.st == ISSUE);
    assign resp_ready  = (ctl.st == WAIT);
    assign cmd_write   = ctl.write;
    assign cmd_address = ctl.addr;
    assign cmd_data    = ctl.data;

    assign poll_now  = (ctl.st == IDLE) && en_q && (poll_cnt == 16'd0);
    assign resp_fire = (ctl.st == WAIT) && resp_valid;
    // A response on the same edge as the deadline takes precedence.
    assign timeout_fire = (TIMEOUT_CYCLES != 0) && (ctl.st == WAIT) &&
                          !resp_valid && (wait_cnt == TO_LAST);

    always_comb begin
        ctl_next = ctl;
        case (ctl.st)
            ISSUE:   if (cmd_ready) ctl_next.st = WAIT;
            WAIT:    if (resp_fire || timeout_fire) ctl_next.st = IDLE;
            default: ctl_next = ctl;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // The host is still waiting on an in-flight request.
            if (ctl.st == ISSUE || ctl.st == WAIT) respond(ctl.write, 32'd0, 1'b1);
            ctl            <= '{st: IDLE, write: 1'b0, addr: '0, data: '0};
            poll_cnt       <= POLL_RELOAD;
            poll_odd       <= 1'b0;
            wait_cnt       <= '0;
            timeout_count  <= '0;
            spurious_count <= '0;
        end else begin
            ctl <= poll_now ? poll_host(ctl_next, poll_odd) : ctl_next;

            if (poll_now) begin
                poll_cnt <= POLL_RELOAD;
                poll_odd <= ~poll_odd;
            end else if (ctl.st == IDLE && en_q) begin
                poll_cnt <= poll_cnt - 16'd1;
            end

            wait_cnt <= (ctl.st == WAIT) ? wait_cnt + 32'd1 : 32'd0;

            if (resp_fire) begin
                respond(ctl.write, resp_data, resp_error);
            end else if (timeout_fire) begin
                respond(ctl.write, 32'd0, 1'b1);
                if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
            end

            if (resp_valid && ctl.st != WAIT && spurious_count != 16'hFFFF)
                spurious_count <= spurious_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_esi_cosim_mmio_bridge.sv
// Bench for esi_cosim_mmio_bridge: host model queues drive requests,
// directed and random transactions are checked against expected responses.

module tb_esi_cosim_mmio_bridge;
    import esi_cosim_mmio_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic        cmd_write;
    logic [31:0] cmd_address;
    logic [31:0] cmd_data;
    logic        resp_valid = 1'b0;
    logic        resp_ready;
    logic [31:0] resp_data = '0;
    logic        resp_error = 1'b0;
    logic [15:0] timeout_count;
    logic [15:0] spurious_count;
    logic        enabled;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    esi_cosim_mmio_bridge #(.POLL_INTERVAL(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_data(cmd_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_error(resp_error),
        .timeout_count(timeout_count), .spurious_count(spurious_count),
        .enabled(enabled)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned poll_calls();
        return rd_polls + wr_polls;
    endfunction

    task automatic wait_valid(output bit seen);
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (cmd_valid) seen = 1;
        end
    endtask

    // One full host transaction; expected values come from the arguments.
    task automatic run_txn(input string tag, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input int rdly, input int lat,
                           input logic [31:0] rdata, input bit rerr);
        int  rd_n = rd_resp_data_q.size();
        int  wr_n = wr_resp_err_q.size();
        bit  seen = 0;
        int  pend = 0;
        logic [31:0] exp_d = w ? d : 32'd0;
        if (w) begin
            wr_addr_q.push_back(a);
            wr_data_q.push_back(d);
        end else begin
            rd_req_q.push_back(a);
        end
        for (int i = 0; i < 60 && !seen; i++) begin
            pend = w ? wr_addr_q.size() : rd_req_q.size();
            @(negedge clk);
            if (cmd_valid) seen = 1;
        end
        chk({tag, "_seen"}, 80'(seen), 80'(1));
        if (!seen) return;
        // Valid must appear on the cycle right after the edge that took the request.
        chk({tag, "_poll_lat"}, 80'({pend, (w ? wr_addr_q.size() : rd_req_q.size())}),
            80'({32'd1, 32'd0}));
        chk({tag, "_cmd"}, 80'({cmd_write, cmd_address, cmd_data}), 80'({w, a, exp_d}));
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            chk({tag, "_stable"}, 80'({cmd_valid, cmd_write, cmd_address, cmd_data}),
                80'({1'b1, w, a, exp_d}));
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        chk({tag, "_wait"}, 80'({cmd_valid, resp_ready}), 80'({1'b0, 1'b1}));
        repeat (lat) @(negedge clk);
        resp_valid = 1'b1;
        resp_data  = rdata;
        resp_error = rerr;
        @(negedge clk);
        resp_valid = 1'b0;
        resp_data  = '0;
        resp_error = 1'b0;
        if (w) begin
            chk({tag, "_wresp"}, 80'({wr_resp_err_q.size(), 32'(wr_resp_err_q[$])}),
                80'({wr_n + 1, 32'(rerr)}));
        end else begin
            chk({tag, "_rresp"}, 80'({rd_resp_data_q.size(), rd_resp_data_q[$],
                                      8'(rd_resp_err_q[$])}),
                80'({rd_n + 1, rdata, 8'(rerr)}));
        end
        chk({tag, "_idle"}, 80'(resp_ready), 80'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen;
        int unsigned c0, prd, pwr;
        int          n0;
        logic [31:0] a, d, rd;
        bit          w, e;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_outs", 80'({cmd_valid, cmd_write, cmd_address, cmd_data, resp_ready}),
            80'(0));
        chk("rst_cnts", 80'({timeout_count, spurious_count}), 80'(0));
        chk("enabled", 80'(enabled), 80'(1));
        chk("rst_no_poll", 80'(poll_calls()), 80'(0));
        rst = 1'b0;

        // Idle polls every 4 edges, write-first then read
        repeat (3) @(negedge clk);
        chk("poll_edge3", 80'(poll_calls()), 80'(0));
        @(negedge clk);
        chk("poll_edge4", 80'({wr_polls, rd_polls}), 80'({32'd1, 32'd1}));
        repeat (3) @(negedge clk);
        chk("poll_edge7", 80'(poll_calls()), 80'(2));
        @(negedge clk);
        chk("poll_edge8", 80'(poll_calls()), 80'(4));

        // Both pending: even poll takes the write and skips the read poll
        wr_addr_q.push_back(32'h0000_0030);
        wr_data_q.push_back(32'hDEAD_BEEF);
        rd_req_q.push_back(32'h0000_0034);
        repeat (3) @(negedge clk);
        chk("both_edge11", 80'({cmd_valid, poll_calls()}), 80'({1'b0, 32'd4}));
        @(negedge clk);
        chk("both_write_first",
            80'({cmd_valid, cmd_write, cmd_address, cmd_data}),
            80'({1'b1, 1'b1, 32'h30, 32'hDEAD_BEEF}));
        chk("both_skip_read", 80'({wr_polls, rd_polls}), 80'({32'd3, 32'd2}));
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready  = 1'b0;
        resp_valid = 1'b1;
        @(negedge clk);
        resp_valid = 1'b0;
        chk("both_wresp", 80'({wr_resp_err_q.size(), 32'(wr_resp_err_q[$])}),
            80'({32'd1, 32'd0}));
        // Odd poll: read first and hits, so no write poll on that edge
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            prd = rd_polls;
            pwr = wr_polls;
            @(negedge clk);
            if (cmd_valid) seen = 1;
        end
        chk("both_read_seen", 80'(seen), 80'(1));
        chk("both_read_first", 80'({rd_polls - prd, wr_polls - pwr}), 80'({32'd1, 32'd0}));
        chk("both_read_cmd", 80'({cmd_write, cmd_address, cmd_data}),
            80'({1'b0, 32'h34, 32'd0}));
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_data  = 32'h0BAD_F00D;
        @(negedge clk);
        resp_valid = 1'b0;
        resp_data  = '0;
        chk("both_rresp", 80'({rd_resp_data_q[$], 8'(rd_resp_err_q[$])}),
            80'({32'h0BAD_F00D, 8'd0}));

        // Directed read and write with a stalled command
        run_txn("read10", 1'b0, 32'h10, 32'h0, 0, 2, 32'hCAFE_F00D, 1'b0);
        run_txn("write20", 1'b1, 32'h20, 32'h1234_5678, 5, 1, 32'h0, 1'b0);

        // Timeout after 8 WAIT cycles
        rd_req_q.push_back(32'h40);
        wait_valid(seen);
        chk("to_seen", 80'(seen), 80'(1));
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        n0 = rd_resp_data_q.size();
        repeat (7) @(negedge clk);
        chk("to_cycle7", 80'({resp_ready, n0 == rd_resp_data_q.size()}), 80'({1'b1, 1'b1}));
        @(negedge clk);
        chk("to_resp", 80'({rd_resp_data_q.size(), rd_resp_data_q[$], 8'(rd_resp_err_q[$])}),
            80'({n0 + 1, 32'd0, 8'd1}));
        chk("to_count", 80'({timeout_count, resp_ready}), 80'({16'd1, 1'b0}));

        // Response exactly on the deadline edge wins
        rd_req_q.push_back(32'h44);
        wait_valid(seen);
        chk("to_race_seen", 80'(seen), 80'(1));
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        n0 = rd_resp_data_q.size();
        repeat (7) @(negedge clk);
        resp_valid = 1'b1;
        resp_data  = 32'hA5A5_0001;
        @(negedge clk);
        resp_valid = 1'b0;
        resp_data  = '0;
        chk("to_race_resp",
            80'({rd_resp_data_q.size(), rd_resp_data_q[$], 8'(rd_resp_err_q[$])}),
            80'({n0 + 1, 32'hA5A5_0001, 8'd0}));
        chk("to_race_count", 80'(timeout_count), 80'(1));

        // Spurious responses in IDLE
        n0 = rd_resp_data_q.size() + wr_resp_err_q.size();
        for (int i = 0; i < 3; i++) begin
            resp_valid = 1'b1;
            @(negedge clk);
            chk("spur_ready", 80'(resp_ready), 80'(0));
        end
        resp_valid = 1'b0;
        @(negedge clk);
        chk("spur_count", 80'(spurious_count), 80'(3));
        chk("spur_no_resp", 80'(rd_resp_data_q.size() + wr_resp_err_q.size()), 80'(n0));

        // Random transactions
        for (int i = 0; i < 16; i++) begin
            w  = 1'($urandom_range(0, 1));
            a  = $urandom;
            d  = $urandom;
            rd = $urandom;
            e  = 1'($urandom_range(0, 1));
            run_txn("rand", w, a, d, $urandom_range(0, 3), $urandom_range(0, 6), rd, e);
        end
        chk("rand_no_timeout", 80'(timeout_count), 80'(1));

        // Asynchronous reset during WAIT of a write
        wr_addr_q.push_back(32'h80);
        wr_data_q.push_back(32'h5555_AAAA);
        wait_valid(seen);
        chk("rstw_seen", 80'(seen), 80'(1));
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        repeat (2) @(negedge clk);
        n0 = wr_resp_err_q.size();
        #2 rst = 1'b1;
        #1;
        chk("rstw_resp", 80'({wr_resp_err_q.size(), 32'(wr_resp_err_q[$])}),
            80'({n0 + 1, 32'd1}));
        chk("rstw_outs", 80'({cmd_valid, cmd_write, cmd_address, cmd_data, resp_ready}),
            80'(0));
        chk("rstw_cnts", 80'({timeout_count, spurious_count}), 80'(0));
        repeat (2) @(negedge clk);
        chk("rstw_once", 80'(wr_resp_err_q.size()), 80'(n0 + 1));
        rst = 1'b0;
        c0 = poll_calls();
        repeat (3) @(negedge clk);
        chk("rstw_edge3", 80'(poll_calls()), 80'(c0));
        @(negedge clk);
        chk("rstw_edge4", 80'(poll_calls()), 80'(c0 + 2));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
